clkdiv_multi: RTL and testbench

Multi-channel, runtime-programmable clock-enable generator. Each channel divides the system clock by a loadable terminal count and produces two outputs: a 50 % duty square wave and a one-cycle strobe on each rising edge of that square wave. It serves display multiplexing, debouncing and slow FSM timing, so several rates come from one block instead of one fixed-rate divider per rate. All logic runs in the single system clock domain. Downstream logic uses the strobes as clock enables and must not use the square waves as clocks.

---
 rtl/clkdiv_multi.sv | 69 ++++++
 tb/tb_clkdiv_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: N_CH independent runtime-programmable clock-enable generators.
// Each channel outputs a 50% square wave and a one-cycle strobe on its rising edge.
module clkdiv_multi #(
    parameter int          CNT_W    = 26,
    parameter int          N_CH     = 4,
    parameter int unsigned INIT_LIM = 24999999,
    localparam int         CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             load,
    input  logic [CH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0] load_val,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_LIM);
    localparam logic [CH_W:0]    N_CH_V = (CH_W + 1)'(N_CH);

    logic [CNT_W-1:0] cnt [N_CH];
    logic [CNT_W-1:0] lim [N_CH];
    logic [N_CH-1:0]  sel;

    // Out-of-range indices (possible when N_CH is not a power of two) select nothing.
    always_comb begin
        sel = '0;
        if (load && ({1'b0, load_ch} < N_CH_V)) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                sel[i] = (load_ch == CH_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (rst) begin
                cnt[i]     <= '0;
                lim[i]     <= INIT_V;
                clk_out[i] <= 1'b0;
                tick[i]    <= 1'b0;
            end else begin
                // A load lands in lim even when sync wins the phase clear.
                if (sel[i]) begin
                    lim[i] <= load_val;
                end
                if (sync || sel[i]) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else if (en[i]) begin
                    if (cnt[i] == lim[i]) begin
                        cnt[i]     <= '0;
                        clk_out[i] <= ~clk_out[i];
                        tick[i]    <= ~clk_out[i];
                    end else begin
                        cnt[i]  <= cnt[i] + 1'b1;
                        tick[i] <= 1'b0;
                    end
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: a phase-position model checked every cycle against two
// instances (4 channels, and 3 channels to exercise out-of-range load indices).
module tb_clkdiv_multi;

    logic       clk = 1'b0;
    logic       rst, sync, load;
    logic [3:0] en;
    logic [1:0] load_ch;
    logic [3:0] load_val;
    logic [3:0] clk_a, tick_a;
    logic [2:0] clk_b, tick_b;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    clkdiv_multi #(.CNT_W(4), .N_CH(4), .INIT_LIM(9)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .load(load),
        .load_ch(load_ch), .load_val(load_val), .clk_out(clk_a), .tick(tick_a)
    );

    clkdiv_multi #(.CNT_W(4), .N_CH(3), .INIT_LIM(2)) dut_b (
        .clk(clk), .rst(rst), .en(en[2:0]), .sync(sync), .load(load),
        .load_ch(load_ch), .load_val(load_val), .clk_out(clk_b), .tick(tick_b)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: each channel is a position within its 2*(lim+1) enabled-cycle period.
    int mlim [2][4];
    int mpos [2][4];
    bit mtk  [2][4];
    bit hit;

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int init_lim(input int k);
        return (k == 0) ? 9 : 2;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < nch(k); c++) begin
                hit = load && (int'(load_ch) == c) && (int'(load_ch) < nch(k));
                if (rst) begin
                    mlim[k][c] = init_lim(k);
                    mpos[k][c] = 0;
                    mtk[k][c]  = 1'b0;
                end else begin
                    if (hit) mlim[k][c] = int'(load_val);
                    if (sync || hit) begin
                        mpos[k][c] = 0;
                        mtk[k][c]  = 1'b0;
                    end else if (en[c]) begin
                        mpos[k][c] = (mpos[k][c] + 1) % (2 * (mlim[k][c] + 1));
                        mtk[k][c]  = (mpos[k][c] == mlim[k][c] + 1);
                    end else begin
                        mtk[k][c] = 1'b0;
                    end
                end
            end
        end
    end

    // Packed as {clk_out, tick, cnt[3:0], lim[3:0]}.
    function automatic longint model_word(input int k, input int c);
        longint hi, cn;
        hi = (mpos[k][c] >= mlim[k][c] + 1) ? 1 : 0;
        cn = mpos[k][c] % (mlim[k][c] + 1);
        return (hi << 9) | (longint'(mtk[k][c]) << 8) | (cn << 4) | longint'(mlim[k][c]);
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int c = 0; c < 4; c++)
                check($sformatf("a_ch%0d", c),
                      {clk_a[c], tick_a[c], dut_a.cnt[c], dut_a.lim[c]}, model_word(0, c));
            for (int c = 0; c < 3; c++)
                check($sformatf("b_ch%0d", c),
                      {clk_b[c], tick_b[c], dut_b.cnt[c], dut_b.lim[c]}, model_word(1, c));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [3:0] v);
        load = 1'b1; load_ch = ch; load_val = v;
        cyc();
        load = 1'b0;
    endtask

    // Sample index 0 is the current cycle.
    int tfirst [4];
    int tsecond [4];
    task automatic tick_times(input int n);
        for (int c = 0; c < 4; c++) begin tfirst[c] = -1; tsecond[c] = -1; end
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (tick_a[c]) begin
                    if (tfirst[c] < 0) tfirst[c] = k;
                    else if (tsecond[c] < 0) tsecond[c] = k;
                end
            end
            cyc();
        end
    endtask

    initial begin
        logic [15:0] wave, tw;
        logic [7:0]  w8, t8;
        int n, hi, nt, wraps, pc;
        logic pclk;

        rst = 1'b1; sync = 1'b0; load = 1'b0; en = 4'h0; load_ch = '0; load_val = '0;
        checking = 1'b1;
        cyc();
        check("rst_clk_out", clk_a, 0);
        check("rst_tick", tick_a, 0);
        check("rst_lim_a", dut_a.lim[0], 9);
        check("rst_lim_b", dut_b.lim[1], 2);
        cyc();
        rst = 1'b0; en = 4'hF;

        do_load(2'd0, 4'd3);
        for (int k = 0; k < 16; k++) begin
            wave[k] = clk_a[0]; tw[k] = tick_a[0];
            cyc();
        end
        check("lim3_wave", wave, 16'hF0F0);
        check("lim3_tick", tw, 16'h1010);

        do_load(2'd1, 4'd0);
        do_load(2'd2, 4'd1);
        for (int k = 0; k < 8; k++) begin
            w8[k] = clk_a[2]; t8[k] = tick_a[2];
            cyc();
        end
        check("lim1_wave", w8, 8'hCC);
        check("lim1_tick", t8, 8'h44);
        do_load(2'd2, 4'd1);
        cyc(4);

        n = 0;
        while (!tick_a[0] && n < 20) begin cyc(); n++; end
        check("gate_find_tick", tick_a[0], 1);
        hi = 1; nt = 0; en[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (clk_a[0]) hi++;
            if (tick_a[0]) nt++;
        end
        en[0] = 1'b1;
        n = 0;
        cyc();
        while (clk_a[0] && n < 20) begin
            hi++;
            if (tick_a[0]) nt++;
            cyc(); n++;
        end
        check("gate_high_len", hi, 9);
        check("gate_no_tick", nt, 0);

        do_load(2'd3, 4'd7);
        cyc(5);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        check("sync_clk0", clk_a[0], 0);
        check("sync_clk3", clk_a[3], 0);
        check("sync_cnt0", dut_a.cnt[0], 0);
        check("sync_cnt3", dut_a.cnt[3], 0);
        tick_times(40);
        check("sync_first0", tfirst[0], 4);
        check("sync_second0", tsecond[0], 12);
        check("sync_first3", tfirst[3], 8);
        check("sync_second3", tsecond[3], 24);

        sync = 1'b1; load = 1'b1; load_ch = 2'd3; load_val = 4'd5;
        cyc();
        sync = 1'b0; load = 1'b0;
        check("syncload_lim3", dut_a.lim[3], 5);
        tick_times(30);
        check("syncload_first3", tfirst[3], 6);
        check("syncload_second3", tsecond[3], 18);
        check("badch_lim_b0", dut_b.lim[0], 3);
        check("badch_lim_b1", dut_b.lim[1], 0);
        check("badch_lim_b2", dut_b.lim[2], 1);

        n = 0;
        while (!(dut_a.cnt[0] == 4'd3 && !clk_a[0]) && n < 20) begin cyc(); n++; end
        check("midrst_find", {clk_a[0], dut_a.cnt[0]}, 5'h03);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_clk", clk_a, 0);
        check("midrst_tick", tick_a, 0);
        check("midrst_lim0", dut_a.lim[0], 9);
        check("midrst_lim3", dut_a.lim[3], 9);

        do_load(2'd2, 4'd15);
        wraps = 0;
        pc = int'(dut_a.cnt[2]); pclk = clk_a[2];
        for (int k = 1; k <= 32; k++) begin
            cyc();
            if (pc == 15 && dut_a.cnt[2] == 4'd0 && clk_a[2] != pclk) wraps++;
            pc = int'(dut_a.cnt[2]); pclk = clk_a[2];
        end
        check("lim15_wraps", wraps, 2);
        tick_times(60);
        check("lim15_first", tfirst[2], 16);
        check("lim15_second", tsecond[2], 48);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
